// File: rtl/mdio_phy_responder_if.sv
// -----------------------------------------------------------------------------
// mdio_phy_responder_if
//
// MDIO management bus between a MAC (station management master) and the PHY
// responder.
//
// Signals:
//   mdc       management clock, driven by the MAC
//   mdio_in   MDIO pad input as seen by the PHY
//   mdio_out  MDIO value the PHY drives when enabled
//   mdio_oen  PHY output enable, active-low (0 = PHY drives the pad)
//
// Protocol: the MAC changes mdio_in while mdc is low. The PHY samples mdio_in
// on the rising edge of mdc. The PHY changes mdio_out/mdio_oen only just after
// a rising mdc edge, so the MAC sees a stable value at the next rising edge.
// There is no valid/ready pair: every rising mdc edge carries exactly one bit.
// -----------------------------------------------------------------------------
interface mdio_phy_responder_if;
   logic mdc;
   logic mdio_in;
   logic mdio_out;
   logic mdio_oen;

   modport master (
      output mdc,
      output mdio_in,
      input  mdio_out,
      input  mdio_oen
   );

   modport slave (
      input  mdc,
      input  mdio_in,
      output mdio_out,
      output mdio_oen
   );
endinterface

// File: rtl/mdio_phy_responder.sv
// -----------------------------------------------------------------------------
// mdio_phy_responder
//
// IEEE 802.3 Clause 22 MDIO management responder (PHY side). MDC and MDIO are
// oversampled in the clk_clk domain. Each synchronized rising MDC edge is one
// bit event. Frames addressed to PHY_ADDR read or write a small register file:
//   reg 0      control, RW (bit 15 = soft reset, self-clearing)
//   reg 1      status, RO = 16'h7949 | (link_up << 2)
//   reg 2/3    PHY_ID1 / PHY_ID2, RO
//   reg 16-31  scratch, RW, reset to 0
//   others     read 0, writes ignored
//
// Ports:
//   clk_clk        system clock (at least 4x the MDC frequency)
//   reset_reset_n  asynchronous active-low reset
//   mdio           MDIO bus (slave modport): mdc, mdio_in, mdio_out, mdio_oen
//   link_up        link status, reported in reg 1 bit 2
//   ctrl_reg       current reg 0 contents
//   wr_valid       one-cycle pulse on each committed write to a RW register
//   wr_addr        register address of the last committed write
//   wr_data        data of the last committed write (as written)
//   fsm_state      frame decoder state, for debug and checkers
//
// Build option:
//   MDIO_PREAMBLE_SUPPRESS_EN  when defined, a single 1 before the start
//                              pattern is enough preamble; otherwise at least
//                              32 consecutive 1s are required.
// -----------------------------------------------------------------------------
module mdio_phy_responder #(
   parameter logic [4:0]  PHY_ADDR    = 5'd1,
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] CTRL_RESET  = 16'h1140,
   parameter logic [15:0] PHY_ID1     = 16'h0141,
   parameter logic [15:0] PHY_ID2     = 16'h0CC2
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   mdio_phy_responder_if.slave  mdio,
   input  logic                 link_up,
   output logic [15:0]          ctrl_reg,
   output logic                 wr_valid,
   output logic [4:0]           wr_addr,
   output logic [15:0]          wr_data,
   output logic [2:0]           fsm_state
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   localparam logic [5:0] PRE_MIN = 6'd1;
`else
   localparam logic [5:0] PRE_MIN = 6'd32;
`endif

   localparam logic [15:0] STATUS_BASE = 16'h7949;
   // Soft reset bit never reads back as 1.
   localparam logic [15:0] CTRL_MASK   = 16'h7FFF;

   typedef enum logic [2:0] {
      IDLE, START, OP, PHYAD, REGAD, TA, DATA, SKIP
   } state_t;

   state_t state_q, state_d;

   // ---------------------------------------------------------------------------
   // Synchronizers and MDC rising-edge detection
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] mdc_sync;
   logic [SYNC_STAGES-1:0] mdio_sync;
   logic                   mdc_prev;
   logic                   bit_evt;
   logic                   bit_val;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         mdc_sync  <= '0;
         mdio_sync <= '0;
         mdc_prev  <= 1'b0;
      end else begin
         mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdio.mdc};
         mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio.mdio_in};
         mdc_prev  <= mdc_sync[SYNC_STAGES-1];
      end
   end

   assign bit_evt = mdc_sync[SYNC_STAGES-1] & ~mdc_prev;
   assign bit_val = mdio_sync[SYNC_STAGES-1];

   // ---------------------------------------------------------------------------
   // Frame decoder state
   // ---------------------------------------------------------------------------
   logic [5:0]  pre_cnt_q, pre_cnt_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic        op_first_q, op_first_d;
   logic        is_read_q, is_read_d;
   logic [4:0]  phyad_q, phyad_d;
   logic [4:0]  regad_q, regad_d;
   logic [15:0] rd_sr_q, rd_sr_d;
   // Holds D15..D1 of a write; D0 arrives with the commit event.
   logic [14:0] wr_sr_q, wr_sr_d;
   logic        out_q, out_d;
   logic        oen_q, oen_d;
   logic        commit;
   logic [4:0]  regad_full;
   logic [15:0] rd_mux;
   logic [15:0] commit_data;

   logic [15:0] ctrl_q;
   logic [15:0] scratch_q [16];

   assign regad_full  = {regad_q[3:0], bit_val};
   assign commit_data = {wr_sr_q, bit_val};

   // Read value for the address completing on this event.
   always_comb begin
      rd_mux = 16'h0000;
      case (regad_full)
         5'd0:    rd_mux = ctrl_q;
         5'd1:    rd_mux = STATUS_BASE | {13'd0, link_up, 2'd0};
         5'd2:    rd_mux = PHY_ID1;
         5'd3:    rd_mux = PHY_ID2;
         default: if (regad_full[4]) rd_mux = scratch_q[regad_full[3:0]];
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q    <= IDLE;
         pre_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         op_first_q <= 1'b0;
         is_read_q  <= 1'b0;
         phyad_q    <= '0;
         regad_q    <= '0;
         rd_sr_q    <= '0;
         wr_sr_q    <= '0;
         out_q      <= 1'b1;
         oen_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         op_first_q <= op_first_d;
         is_read_q  <= is_read_d;
         phyad_q    <= phyad_d;
         regad_q    <= regad_d;
         rd_sr_q    <= rd_sr_d;
         wr_sr_q    <= wr_sr_d;
         out_q      <= out_d;
         oen_q      <= oen_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pre_cnt_d  = (state_q == IDLE) ? pre_cnt_q : 6'd0;
      bit_cnt_d  = bit_cnt_q;
      op_first_d = op_first_q;
      is_read_d  = is_read_q;
      phyad_d    = phyad_q;
      regad_d    = regad_q;
      rd_sr_d    = rd_sr_q;
      wr_sr_d    = wr_sr_q;
      out_d      = out_q;
      oen_d      = oen_q;
      commit     = 1'b0;

      if (bit_evt) begin
         case (state_q)
            IDLE: begin
               if (bit_val) begin
                  if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
               end else if (pre_cnt_q >= PRE_MIN) begin
                  // This 0 is the first start bit.
                  state_d   = START;
                  pre_cnt_d = 6'd0;
               end else begin
                  pre_cnt_d = 6'd0;
               end
            end
            START: begin
               bit_cnt_d = 5'd0;
               state_d   = bit_val ? OP : IDLE;
            end
            OP: begin
               if (bit_cnt_q == 5'd0) begin
                  op_first_d = bit_val;
                  bit_cnt_d  = 5'd1;
               end else begin
                  bit_cnt_d = 5'd0;
                  // 10 = read, 01 = write, anything else aborts.
                  if (op_first_q != bit_val) begin
                     is_read_d = op_first_q;
                     state_d   = PHYAD;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            PHYAD: begin
               phyad_d = {phyad_q[3:0], bit_val};
               if (bit_cnt_q == 5'd4) begin
                  bit_cnt_d = 5'd0;
                  state_d   = REGAD;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
            REGAD: begin
               regad_d = regad_full;
               if (bit_cnt_q == 5'd4) begin
                  bit_cnt_d = 5'd0;
                  if (phyad_q == PHY_ADDR) begin
                     state_d = TA;
                     // Snapshot so fabric changes cannot alter this frame.
                     rd_sr_d = rd_mux;
                  end else begin
                     state_d = SKIP;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
            TA: begin
               if (bit_cnt_q == 5'd0) begin
                  bit_cnt_d = 5'd1;
                  if (is_read_q) begin
                     // Turnaround zero, seen by the MAC in TA bit 2.
                     oen_d = 1'b0;
                     out_d = 1'b0;
                  end
               end else begin
                  bit_cnt_d = 5'd0;
                  state_d   = DATA;
                  if (is_read_q) begin
                     out_d   = rd_sr_q[15];
                     rd_sr_d = {rd_sr_q[14:0], 1'b0};
                  end
               end
            end
            DATA: begin
               if (bit_cnt_q == 5'd15) begin
                  bit_cnt_d = 5'd0;
                  state_d   = IDLE;
                  out_d     = 1'b1;
                  oen_d     = 1'b1;
                  commit    = ~is_read_q;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (is_read_q) begin
                     out_d   = rd_sr_q[15];
                     rd_sr_d = {rd_sr_q[14:0], 1'b0};
                  end else begin
                     wr_sr_d = {wr_sr_q[13:0], bit_val};
                  end
               end
            end
            SKIP: begin
               // Frame for another PHY: TA + 16 data bits = 18 events.
               if (bit_cnt_q == 5'd17) begin
                  bit_cnt_d = 5'd0;
                  state_d   = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Register file and write reporting
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         ctrl_q   <= CTRL_RESET & CTRL_MASK;
         for (int i = 0; i < 16; i++) scratch_q[i] <= 16'h0000;
         wr_valid <= 1'b0;
         wr_addr  <= 5'd0;
         wr_data  <= 16'h0000;
      end else begin
         wr_valid <= 1'b0;
         if (commit) begin
            if (regad_q == 5'd0) begin
               wr_valid <= 1'b1;
               wr_addr  <= regad_q;
               wr_data  <= commit_data;
               if (commit_data[15]) begin
                  ctrl_q <= CTRL_RESET & CTRL_MASK;
                  for (int i = 0; i < 16; i++) scratch_q[i] <= 16'h0000;
               end else begin
                  ctrl_q <= commit_data & CTRL_MASK;
               end
            end else if (regad_q[4]) begin
               wr_valid                <= 1'b1;
               wr_addr                 <= regad_q;
               wr_data                 <= commit_data;
               scratch_q[regad_q[3:0]] <= commit_data;
            end
         end
      end
   end

   assign mdio.mdio_out = out_q;
   assign mdio.mdio_oen = oen_q;
   assign ctrl_reg      = ctrl_q;
   assign fsm_state     = state_q;

endmodule
